// File: rtl/ifu_pc_gen.sv
// Fetch PC generator: one outstanding imem request, valid/ready delivery to decode,
// and redirect handling that kills wrong-path fetches. Latency 1 cycle from redirect to new request.
module ifu_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  input  logic        bjmp,
  input  logic [31:0] bpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        if_ready,
  output logic        flush_id,
  output logic        misalign,
  output logic [31:0] redir_cnt
);

  localparam logic [31:0] LP_STEP = 32'(PC_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        w_latch;
  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_flush_id;
  logic        r_misalign;
  logic [31:0] r_redir_cnt;

  assign w_redir  = exe_valid & bjmp;
  assign w_target = {bpc[31:2], 2'b00};

  // A redirect always wins; the only thing it leaves to the other inputs is
  // whether a request is still in flight (and so whether we must DROP).
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_latch     = 1'b0;
    if (w_redir) begin
      w_pc_nxt = w_target;
    end
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          w_state_nxt = w_redir ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redir) begin
          w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          w_latch     = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_redir) begin
          w_state_nxt = S_REQ;
        end else if (if_ready) begin
          w_pc_nxt    = r_pc + LP_STEP;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_if_pc     <= 32'h0;
      r_if_inst   <= 32'h0;
      r_flush_id  <= 1'b0;
      r_misalign  <= 1'b0;
      r_redir_cnt <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_flush_id <= w_redir;
      r_misalign <= w_redir & (|bpc[1:0]);
      if (w_latch) begin
        r_if_pc   <= r_pc;
        r_if_inst <= imem_rdata;
      end
      if (w_redir) begin
        r_redir_cnt <= r_redir_cnt + 32'd1;
      end
    end
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign if_valid  = (r_state == S_HOLD);
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;
  assign flush_id  = r_flush_id;
  assign misalign  = r_misalign;
  assign redir_cnt = r_redir_cnt;

endmodule
